// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, opcode and program-length constants for the fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_ISSUE = 2'b10,
    ST_HALT  = 2'b11
  } fetch_state_e;

  localparam int OPC_W = 4;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

  // Also sizes eight_bit_rom, so both sides agree on where the PC wraps.
  localparam int PROG_LEN_DEFAULT = 16;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - ROM port and instruction valid/ready handshake bundle
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8
);

  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_addr;

  modport master (
    output rom_addr, instr, instr_valid,
    input  rom_data, instr_ready, jump_en, jump_addr
  );

  modport slave (
    input  rom_addr, instr, instr_valid,
    output rom_data, instr_ready, jump_en, jump_addr
  );

endinterface

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - program counter with increment/wrap/jump and sticky out-of-range flag
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int PROG_LEN = PROG_LEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              advance,
  input  logic              clear,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              addr_err
);

  // One extra bit so PROG_LEN == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   LEN  = (ADDR_W+1)'(PROG_LEN);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;
  logic              jump_bad;

  always_comb begin
    jump_bad = jump_en && ({1'b0, jump_addr} >= LEN);

    if (jump_en && !jump_bad) begin
      pc_next = jump_addr;
    end else if (jump_en) begin
      pc_next = '0;
    end else if (pc_q == LAST) begin
      pc_next = '0;
    end else begin
      pc_next = pc_q + ADDR_W'(1);
    end

    pc_d  = pc_q;
    err_d = err_q;
    if (clear) begin
      pc_d  = '0;
      err_d = 1'b0;
    end else if (advance) begin
      pc_d = pc_next;
      if (jump_bad) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign pc       = pc_q;
  assign addr_err = err_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch FSM (step/run/halt); breakpoints under FETCH_SEQ_BREAKPOINT_EN
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 8,
  parameter int PROG_LEN = PROG_LEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step,
  input  logic              run,
  input  logic              restart,
  fetch_sequencer_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        state,
  output logic              addr_err,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              bp_hit
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               bp_hit_q, bp_hit_d;
  logic               accept;
  logic               pc_clear;
  logic [ADDR_W-1:0]  pc_next;
  logic [OPC_W-1:0]   opcode;

  assign opcode = instr_q[INSTR_W-1 -: OPC_W];

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .PROG_LEN (PROG_LEN)
  ) u_pc (
    .clk       (clk),
    .reset_n   (reset_n),
    .advance   (accept),
    .clear     (pc_clear),
    .jump_en   (bus.jump_en),
    .jump_addr (bus.jump_addr),
    .pc        (pc),
    .pc_next   (pc_next),
    .addr_err  (addr_err)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    bp_hit_d = bp_hit_q;
    accept   = 1'b0;
    pc_clear = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A pending breakpoint holds the core even with run high; only step resumes.
        if (step) begin
          state_d  = ST_FETCH;
          bp_hit_d = 1'b0;
        end else if (run && !bp_hit_q) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        instr_d = bus.rom_data;
        valid_d = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.instr_ready) begin
          accept  = 1'b1;
          valid_d = 1'b0;
          if (opcode == OPC_HALT) begin
            state_d = ST_HALT;
          end else if (run) begin
`ifdef FETCH_SEQ_BREAKPOINT_EN
            if (pc_next == bp_addr) begin
              state_d  = ST_IDLE;
              bp_hit_d = 1'b1;
            end else begin
              state_d = ST_FETCH;
            end
`else
            state_d = ST_FETCH;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        if (restart) begin
          pc_clear = 1'b1;
          bp_hit_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      bp_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      bp_hit_q <= bp_hit_d;
    end
  end

`ifndef FETCH_SEQ_BREAKPOINT_EN
  logic bp_unused;
  assign bp_unused = ^{bp_addr, pc_next};
`endif

  assign bus.rom_addr    = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign state           = state_q;
  assign bp_hit          = bp_hit_q;

endmodule
